// File: rtl/cache_nway_control.sv
// cache_nway_control
//   N-way write-back / write-allocate cache controller FSM. It sits between
//   the cache datapath (tag/data/valid/dirty/LRU arrays) and physical memory.
//   It serves hits in IDLE with zero added latency. A miss picks a victim:
//   the lowest invalid way, otherwise the LRU way. A dirty victim is written
//   back, the line is filled, and the request is then re-serviced as a hit.
//   A flush walker writes back every valid+dirty line in the cache.
//
// Optional feature macro: CACHE_PERF_CNT_EN
//   When defined, this build has saturating 32-bit hit and miss counters.
//   When undefined, hit_count and miss_count are constant zero.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   mem_read/mem_write/mem_resp CPU request (level) and completion pulse
//   hit_vec/valid_vec/dirty_vec per-way status of the current set
//   lru_way                     LRU way of the current set
//   load_lru/load_data/load_tag/load_valid/load_dirty  array write enables
//   dirty_in, data_in_sel       dirty value written / data source select
//   data_way_sel                way for data-out and LRU update
//   addr_sel, set_idx           address source and flush set index
//   pmem_read/pmem_write/pmem_resp  physical memory handshake
//   flush_req/flush_done        flush request and completion pulse
//   hit_count/miss_count        performance counters
module cache_nway_control #(
  parameter  int WAYS  = 4,
  parameter  int SETS  = 8,
  localparam int WAY_W = $clog2(WAYS),
  localparam int SET_W = $clog2(SETS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mem_read,
  input  logic             mem_write,
  output logic             mem_resp,
  input  logic [WAYS-1:0]  hit_vec,
  input  logic [WAYS-1:0]  valid_vec,
  input  logic [WAYS-1:0]  dirty_vec,
  input  logic [WAY_W-1:0] lru_way,
  output logic             load_lru,
  output logic [WAYS-1:0]  load_data,
  output logic [WAYS-1:0]  load_tag,
  output logic [WAYS-1:0]  load_valid,
  output logic [WAYS-1:0]  load_dirty,
  output logic             dirty_in,
  output logic             data_in_sel,
  output logic [WAY_W-1:0] data_way_sel,
  output logic [1:0]       addr_sel,
  output logic [SET_W-1:0] set_idx,
  output logic             pmem_read,
  output logic             pmem_write,
  input  logic             pmem_resp,
  input  logic             flush_req,
  output logic             flush_done,
  output logic [31:0]      hit_count,
  output logic [31:0]      miss_count
);

  typedef enum logic [2:0] {S_IDLE, S_WB, S_FILL, S_FSCAN, S_FWB, S_FDONE} state_e;

  state_e           state_q, state_d;
  logic [WAY_W-1:0] victim_q, victim_d;
  logic [SET_W-1:0] set_cnt_q, set_cnt_d;
  logic [WAY_W-1:0] way_cnt_q, way_cnt_d;
  logic             retry_q, retry_d;

  // Lowest set bit wins; a multi-hit is a datapath error and must still resolve.
  function automatic logic [WAY_W-1:0] lowest_idx(input logic [WAYS-1:0] v);
    lowest_idx = '0;
    for (int i = WAYS - 1; i >= 0; i--)
      if (v[i]) lowest_idx = WAY_W'(i);
  endfunction

  logic             req, hit, last_line, do_adv;
  logic [WAY_W-1:0] hit_idx, victim;
  logic [WAYS-1:0]  hit_oh, vic_oh, cnt_oh;

  assign req       = mem_read | mem_write;
  assign hit       = |hit_vec;
  assign hit_idx   = lowest_idx(hit_vec);
  assign victim    = (&valid_vec) ? lru_way : lowest_idx(~valid_vec);
  assign hit_oh    = WAYS'(1) << hit_idx;
  assign vic_oh    = WAYS'(1) << victim_q;
  assign cnt_oh    = WAYS'(1) << way_cnt_q;
  assign last_line = (set_cnt_q == SET_W'(SETS - 1)) && (way_cnt_q == WAY_W'(WAYS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      victim_q  <= '0;
      set_cnt_q <= '0;
      way_cnt_q <= '0;
      retry_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      victim_q  <= victim_d;
      set_cnt_q <= set_cnt_d;
      way_cnt_q <= way_cnt_d;
      retry_q   <= retry_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    victim_d  = victim_q;
    set_cnt_d = set_cnt_q;
    way_cnt_d = way_cnt_q;
    retry_d   = retry_q;
    do_adv    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // retry_q only marks the first IDLE cycle after a fill.
        retry_d = 1'b0;
        if (req) begin
          if (!hit) begin
            victim_d = victim;
            state_d  = (valid_vec[victim] && dirty_vec[victim]) ? S_WB : S_FILL;
          end
        end else if (flush_req) begin
          state_d   = S_FSCAN;
          set_cnt_d = '0;
          way_cnt_d = '0;
        end
      end
      S_WB:    if (pmem_resp) state_d = S_FILL;
      S_FILL: begin
        if (pmem_resp) begin
          state_d = S_IDLE;
          retry_d = 1'b1;
        end
      end
      S_FSCAN: begin
        if (valid_vec[way_cnt_q] && dirty_vec[way_cnt_q]) state_d = S_FWB;
        else do_adv = 1'b1;
      end
      S_FWB:   if (pmem_resp) do_adv = 1'b1;
      S_FDONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // The walker steps way-major within a set, then moves to the next set.
    if (do_adv) begin
      state_d = last_line ? S_FDONE : S_FSCAN;
      if (way_cnt_q == WAY_W'(WAYS - 1)) begin
        way_cnt_d = '0;
        set_cnt_d = set_cnt_q + SET_W'(1);
      end else begin
        way_cnt_d = way_cnt_q + WAY_W'(1);
      end
    end
  end

  logic             mem_resp_c, load_lru_c, dirty_in_c, data_in_sel_c;
  logic             pmem_read_c, pmem_write_c, flush_done_c;
  logic [WAYS-1:0]  load_data_c, load_tag_c, load_valid_c, load_dirty_c;
  logic [WAY_W-1:0] way_sel_c;
  logic [1:0]       addr_sel_c;
  logic [SET_W-1:0] set_idx_c;

  always_comb begin
    mem_resp_c    = 1'b0;
    load_lru_c    = 1'b0;
    dirty_in_c    = 1'b0;
    data_in_sel_c = 1'b0;
    pmem_read_c   = 1'b0;
    pmem_write_c  = 1'b0;
    flush_done_c  = 1'b0;
    load_data_c   = '0;
    load_tag_c    = '0;
    load_valid_c  = '0;
    load_dirty_c  = '0;
    way_sel_c     = '0;
    addr_sel_c    = 2'd0;
    set_idx_c     = '0;
    unique case (state_q)
      S_IDLE: begin
        if (req && hit) begin
          mem_resp_c = 1'b1;
          load_lru_c = 1'b1;
          way_sel_c  = hit_idx;
          if (mem_write) begin
            load_data_c   = hit_oh;
            load_dirty_c  = hit_oh;
            dirty_in_c    = 1'b1;
            data_in_sel_c = 1'b1;
          end
        end
      end
      S_WB: begin
        pmem_write_c = 1'b1;
        addr_sel_c   = 2'd1;
        way_sel_c    = victim_q;
      end
      S_FILL: begin
        pmem_read_c = 1'b1;
        way_sel_c   = victim_q;
        // Arrays are written only when the memory line is actually present.
        if (pmem_resp) begin
          load_data_c  = vic_oh;
          load_tag_c   = vic_oh;
          load_valid_c = vic_oh;
          load_dirty_c = vic_oh;
        end
      end
      S_FSCAN: begin
        addr_sel_c = 2'd2;
        set_idx_c  = set_cnt_q;
        way_sel_c  = way_cnt_q;
      end
      S_FWB: begin
        pmem_write_c = 1'b1;
        addr_sel_c   = 2'd2;
        set_idx_c    = set_cnt_q;
        way_sel_c    = way_cnt_q;
        if (pmem_resp) load_dirty_c = cnt_oh;
      end
      S_FDONE: flush_done_c = 1'b1;
      default: ;
    endcase
  end

  // Gating with rst_n forces every output low while reset is asserted,
  // including the pmem strobes mid-transaction.
  assign mem_resp     = rst_n & mem_resp_c;
  assign load_lru     = rst_n & load_lru_c;
  assign dirty_in     = rst_n & dirty_in_c;
  assign data_in_sel  = rst_n & data_in_sel_c;
  assign pmem_read    = rst_n & pmem_read_c;
  assign pmem_write   = rst_n & pmem_write_c;
  assign flush_done   = rst_n & flush_done_c;
  assign load_data    = rst_n ? load_data_c  : '0;
  assign load_tag     = rst_n ? load_tag_c   : '0;
  assign load_valid   = rst_n ? load_valid_c : '0;
  assign load_dirty   = rst_n ? load_dirty_c : '0;
  assign data_way_sel = rst_n ? way_sel_c    : '0;
  assign addr_sel     = rst_n ? addr_sel_c   : 2'd0;
  assign set_idx      = rst_n ? set_idx_c    : '0;

`ifdef CACHE_PERF_CNT_EN
  logic        hit_evt, miss_evt;
  logic [31:0] hit_cnt_q, miss_cnt_q;

  // A retry response completes a miss that was already counted.
  assign hit_evt  = (state_q == S_IDLE) && req && hit && !retry_q;
  assign miss_evt = (state_q == S_IDLE) && req && !hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit_evt && (hit_cnt_q != 32'hFFFF_FFFF))   hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (miss_evt && (miss_cnt_q != 32'hFFFF_FFFF)) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_cache_nway_control.sv
module tb_cache_nway_control;
  localparam int WAYS = 4;
  localparam int SETS = 8;
`ifdef CACHE_PERF_CNT_EN
  localparam logic [31:0] EXP_H = 32'd5;
  localparam logic [31:0] EXP_M = 32'd2;
`else
  localparam logic [31:0] EXP_H = 32'd0;
  localparam logic [31:0] EXP_M = 32'd0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic mem_read, mem_write, mem_resp;
  logic [3:0] hit_vec, valid_vec, dirty_vec, valid_drv, dirty_drv;
  logic [1:0] lru_way;
  logic load_lru, dirty_in, data_in_sel, pmem_read, pmem_write, pmem_resp;
  logic [3:0] load_data, load_tag, load_valid, load_dirty;
  logic [1:0] data_way_sel, addr_sel;
  logic [2:0] set_idx;
  logic flush_req, flush_done;
  logic [31:0] hit_count, miss_count;

  // Minimal array model used only during the flush test.
  logic       use_model;
  logic [3:0] valid_arr [SETS];
  logic [3:0] dirty_arr [SETS];
  assign valid_vec = use_model ? valid_arr[set_idx] : valid_drv;
  assign dirty_vec = use_model ? dirty_arr[set_idx] : dirty_drv;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cache_nway_control #(.WAYS(WAYS), .SETS(SETS)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
    .hit_vec(hit_vec), .valid_vec(valid_vec), .dirty_vec(dirty_vec), .lru_way(lru_way),
    .load_lru(load_lru), .load_data(load_data), .load_tag(load_tag),
    .load_valid(load_valid), .load_dirty(load_dirty), .dirty_in(dirty_in),
    .data_in_sel(data_in_sel), .data_way_sel(data_way_sel), .addr_sel(addr_sel),
    .set_idx(set_idx), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_resp(pmem_resp), .flush_req(flush_req), .flush_done(flush_done),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  task automatic idle_in();
    mem_read = 1'b0; mem_write = 1'b0; hit_vec = 4'b0; valid_drv = 4'hF; dirty_drv = 4'h0;
    lru_way = 2'd0; pmem_resp = 1'b0; flush_req = 1'b0; use_model = 1'b0;
  endtask

  task automatic test_reset();
    idle_in();
    rst_n = 1'b0; mem_read = 1'b1; hit_vec = 4'b0001; pmem_resp = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (mem_resp !== 1'b0) begin errors++; $display("FAIL rst_mem_resp got %b exp 0", mem_resp); end
    checks++; if (load_lru !== 1'b0) begin errors++; $display("FAIL rst_load_lru got %b exp 0", load_lru); end
    checks++; if ({pmem_read, pmem_write, flush_done} !== 3'b000) begin errors++; $display("FAIL rst_pmem got %b exp 000", {pmem_read, pmem_write, flush_done}); end
    checks++; if ({hit_count, miss_count} !== 64'd0) begin errors++; $display("FAIL rst_counters got %0d/%0d exp 0/0", hit_count, miss_count); end
    @(negedge clk);
    idle_in(); rst_n = 1'b1;
  endtask

  task automatic test_reset_mid_fill();
    @(negedge clk);
    mem_read = 1'b1; lru_way = 2'd3; #1;
    checks++; if ({mem_resp, pmem_read} !== 2'b00) begin errors++; $display("FAIL mf_miss_cycle got %b exp 00", {mem_resp, pmem_read}); end
    @(negedge clk); #1;
    checks++; if (pmem_read !== 1'b1) begin errors++; $display("FAIL mf_fill_read got %b exp 1", pmem_read); end
    #2 rst_n = 1'b0; #1;
    checks++; if (pmem_read !== 1'b0) begin errors++; $display("FAIL mf_async_drop got %b exp 0", pmem_read); end
    @(negedge clk);
    idle_in(); rst_n = 1'b1; #1;
    checks++; if ({pmem_read, mem_resp, addr_sel} !== 4'b0000) begin errors++; $display("FAIL mf_after_rel got %b exp 0000", {pmem_read, mem_resp, addr_sel}); end
    @(negedge clk);
    mem_read = 1'b1; hit_vec = 4'b1000; #1;
    checks++; if ({mem_resp, data_way_sel} !== 3'b1_11) begin errors++; $display("FAIL mf_idle_hit got %b exp 111", {mem_resp, data_way_sel}); end
    @(negedge clk); idle_in();
  endtask

  task automatic test_read_hit();
    @(negedge clk);
    mem_read = 1'b1; hit_vec = 4'b0100; #1;
    checks++; if ({mem_resp, load_lru} !== 2'b11) begin errors++; $display("FAIL rh_resp_lru got %b exp 11", {mem_resp, load_lru}); end
    checks++; if (data_way_sel !== 2'd2) begin errors++; $display("FAIL rh_way got %0d exp 2", data_way_sel); end
    checks++; if ({pmem_read, pmem_write, load_data} !== 6'b0) begin errors++; $display("FAIL rh_no_pmem got %b exp 000000", {pmem_read, pmem_write, load_data}); end
    @(negedge clk); idle_in();
  endtask

  task automatic test_write_hit();
    @(negedge clk);
    mem_write = 1'b1; hit_vec = 4'b0001; #1;
    checks++; if ({load_data, load_dirty} !== 8'b0001_0001) begin errors++; $display("FAIL wh_loads got %b exp 00010001", {load_data, load_dirty}); end
    checks++; if ({mem_resp, dirty_in, data_in_sel} !== 3'b111) begin errors++; $display("FAIL wh_ctrl got %b exp 111", {mem_resp, dirty_in, data_in_sel}); end
    @(negedge clk); idle_in();
  endtask

  task automatic test_write_miss_dirty();
    @(negedge clk);
    mem_write = 1'b1; valid_drv = 4'b1111; lru_way = 2'd1; dirty_drv = 4'b0010; #1;
    checks++; if ({mem_resp, pmem_write} !== 2'b00) begin errors++; $display("FAIL wm_idle got %b exp 00", {mem_resp, pmem_write}); end
    @(negedge clk); #1;
    checks++; if ({pmem_write, pmem_read, addr_sel, data_way_sel} !== 6'b10_01_01) begin errors++; $display("FAIL wm_wb got %b exp 100101", {pmem_write, pmem_read, addr_sel, data_way_sel}); end
    @(negedge clk); #1;
    checks++; if (pmem_write !== 1'b1) begin errors++; $display("FAIL wm_wb_wait got %b exp 1", pmem_write); end
    @(negedge clk); pmem_resp = 1'b1; #1;
    checks++; if ({pmem_write, load_data} !== 5'b1_0000) begin errors++; $display("FAIL wm_wb_resp got %b exp 10000", {pmem_write, load_data}); end
    @(negedge clk); pmem_resp = 1'b0; #1;
    checks++; if ({pmem_read, pmem_write, addr_sel, load_data} !== 8'b10_00_0000) begin errors++; $display("FAIL wm_fill_wait got %b exp 10000000", {pmem_read, pmem_write, addr_sel, load_data}); end
    @(negedge clk); pmem_resp = 1'b1; #1;
    checks++; if ({load_data, load_tag, load_valid, load_dirty} !== 16'h2222) begin errors++; $display("FAIL wm_fill_loads got %h exp 2222", {load_data, load_tag, load_valid, load_dirty}); end
    checks++; if ({dirty_in, data_in_sel} !== 2'b00) begin errors++; $display("FAIL wm_fill_src got %b exp 00", {dirty_in, data_in_sel}); end
    @(negedge clk); pmem_resp = 1'b0; hit_vec = 4'b0010; #1;
    checks++; if ({mem_resp, load_data, dirty_in, pmem_read} !== 7'b1_0010_1_0) begin errors++; $display("FAIL wm_retry got %b exp 1001010", {mem_resp, load_data, dirty_in, pmem_read}); end
    @(negedge clk); idle_in();
  endtask

  task automatic test_read_miss_clean();
    @(negedge clk);
    mem_read = 1'b1; valid_drv = 4'b1011; lru_way = 2'd0; dirty_drv = 4'b1111; #1;
    checks++; if (mem_resp !== 1'b0) begin errors++; $display("FAIL rm_idle got %b exp 0", mem_resp); end
    @(negedge clk); #1;
    checks++; if ({pmem_read, pmem_write, load_valid} !== 6'b10_0000) begin errors++; $display("FAIL rm_fill_no_wb got %b exp 100000", {pmem_read, pmem_write, load_valid}); end
    @(negedge clk); pmem_resp = 1'b1; #1;
    checks++; if ({load_valid, load_data, load_tag} !== 12'h444) begin errors++; $display("FAIL rm_fill_way2 got %h exp 444", {load_valid, load_data, load_tag}); end
    @(negedge clk); pmem_resp = 1'b0; hit_vec = 4'b0100; #1;
    checks++; if ({mem_resp, data_way_sel} !== 3'b1_10) begin errors++; $display("FAIL rm_retry got %b exp 110", {mem_resp, data_way_sel}); end
    @(negedge clk); idle_in();
  endtask

  task automatic test_perf_counts();
    @(negedge clk);
    mem_read = 1'b1; hit_vec = 4'b1100; #1;
    checks++; if (data_way_sel !== 2'd2) begin errors++; $display("FAIL pc_hit_a got %0d exp 2", data_way_sel); end
    @(negedge clk); idle_in();
    @(negedge clk);
    mem_read = 1'b1; hit_vec = 4'b0110; #1;
    checks++; if (data_way_sel !== 2'd1) begin errors++; $display("FAIL pc_multi_hit got %0d exp 1", data_way_sel); end
    @(negedge clk); idle_in(); #1;
    checks++; if (hit_count !== EXP_H) begin errors++; $display("FAIL pc_hit_count got %0d exp %0d", hit_count, EXP_H); end
    checks++; if (miss_count !== EXP_M) begin errors++; $display("FAIL pc_miss_count got %0d exp %0d", miss_count, EXP_M); end
  endtask

  task automatic test_flush_priority();
    @(negedge clk);
    mem_read = 1'b1; hit_vec = 4'b0001; flush_req = 1'b1; #1;
    checks++; if (mem_resp !== 1'b1) begin errors++; $display("FAIL fp_cpu_first got %b exp 1", mem_resp); end
    @(negedge clk); idle_in(); #1;
    checks++; if (addr_sel !== 2'd0) begin errors++; $display("FAIL fp_no_scan got %0d exp 0", addr_sel); end
  endtask

  task automatic test_flush();
    int bursts, fd_cnt, wcnt;
    bit resp_bad, seen, addr_bad;
    logic [2:0] rec_set [3];
    logic [1:0] rec_way [3];
    logic [3:0] tmp;
    bursts = 0; fd_cnt = 0; wcnt = 0; resp_bad = 0; seen = 0; addr_bad = 0;
    for (int s = 0; s < SETS; s++) begin valid_arr[s] = 4'hF; dirty_arr[s] = 4'h0; end
    dirty_arr[1] = 4'b0001; dirty_arr[3] = 4'b1000; dirty_arr[7] = 4'b1000;
    valid_arr[5] = 4'b1011; dirty_arr[5] = 4'b0100;
    @(negedge clk);
    use_model = 1'b1; flush_req = 1'b1; #1;
    checks++; if (flush_done !== 1'b0) begin errors++; $display("FAIL fl_start got %b exp 0", flush_done); end
    for (int c = 0; c < 600 && !seen; c++) begin
      @(negedge clk);
      flush_req = 1'b0; mem_read = 1'b1; hit_vec = 4'b0001;
      pmem_resp = pmem_write && (wcnt == 2);
      #1;
      if (flush_done) begin fd_cnt++; seen = 1; end
      if (mem_resp) resp_bad = 1;
      if (pmem_write) begin
        if (wcnt == 0) begin
          if (bursts < 3) begin rec_set[bursts] = set_idx; rec_way[bursts] = data_way_sel; end
          if (addr_sel !== 2'd2) addr_bad = 1;
          bursts++;
        end
        wcnt = pmem_resp ? 0 : wcnt + 1;
      end
      if ((load_dirty != 4'b0) && !dirty_in) begin
        tmp = dirty_arr[set_idx] & ~load_dirty;
        dirty_arr[set_idx] = tmp;
      end
    end
    checks++; if (!seen) begin errors++; $display("FAIL fl_timeout got no flush_done exp pulse"); end
    checks++; if (bursts !== 3) begin errors++; $display("FAIL fl_bursts got %0d exp 3", bursts); end
    checks++; if (resp_bad || addr_bad) begin errors++; $display("FAIL fl_resp_addr got %b%b exp 00", resp_bad, addr_bad); end
    if (bursts == 3) begin
      checks++; if ({rec_set[0], rec_way[0], rec_set[1], rec_way[1], rec_set[2], rec_way[2]} !== {3'd1, 2'd0, 3'd3, 2'd3, 3'd7, 2'd3})
        begin errors++; $display("FAIL fl_order got %0d/%0d %0d/%0d %0d/%0d exp 1/0 3/3 7/3", rec_set[0], rec_way[0], rec_set[1], rec_way[1], rec_set[2], rec_way[2]); end
    end
    for (int s = 0; s < SETS; s++) begin
      checks++; if (dirty_arr[s] !== ((s == 5) ? 4'b0100 : 4'b0000)) begin errors++; $display("FAIL fl_dirty_set%0d got %b exp %b", s, dirty_arr[s], (s == 5) ? 4'b0100 : 4'b0000); end
    end
    @(negedge clk); pmem_resp = 1'b0; #1;
    checks++; if ({flush_done, mem_resp} !== 2'b01) begin errors++; $display("FAIL fl_after got %b exp 01", {flush_done, mem_resp}); end
    @(negedge clk); idle_in();
  endtask

  initial begin
    test_reset();
    test_reset_mid_fill();
    test_read_hit();
    test_write_hit();
    test_write_miss_dirty();
    test_read_miss_clean();
    test_perf_counts();
    test_flush_priority();
    test_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
